vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 153 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing source for the overlay pipeline.
// Runs the h/v counters and decodes sync, active video and pixel coordinates
// from them. Also paints the sky/ground background, scrolling the ground
// stripes a little further each frame, and emits a once-per-frame game tick.
// All outputs come from one register stage, so they stay mutually aligned
// and lag the counter state they describe by exactly one clock.
module vga_timing_gen #(
  parameter int          H_ACTIVE    = 1024,
  parameter int          H_FP        = 24,
  parameter int          H_SYNC      = 136,
  parameter int          H_BP        = 160,
  parameter int          V_ACTIVE    = 768,
  parameter int          V_FP        = 3,
  parameter int          V_SYNC      = 6,
  parameter int          V_BP        = 29,
  parameter logic        SYNC_POL    = 1'b0,
  parameter int          GROUND_Y    = 700,
  parameter int          STRIPE_W    = 32,
  parameter int          SCROLL_STEP = 4,
  parameter logic [11:0] SKY_RGB     = 12'h4CF,
  parameter logic [11:0] GROUND_A    = 12'h8C4,
  parameter logic [11:0] GROUND_B    = 12'h6A3
) (
  input  logic        vga_clk,
  input  logic        rstn,
  input  logic        run,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic [11:0] rgb,
  output logic        frame_tick
);

  // Timing boundaries, pre-sized to the 12-bit counter width.
  localparam logic [11:0] H_ACT_C   = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG    = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT_C   = 12'(V_ACTIVE);
  localparam logic [11:0] VS_BEG    = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST    = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] GROUND_C  = 12'(GROUND_Y);
  localparam logic [11:0] STRIPE_C  = 12'(STRIPE_W);
  localparam logic [11:0] STRIPE_P  = 12'(2 * STRIPE_W);
  localparam logic [11:0] STRIPE_LM = 12'(2 * STRIPE_W - 1);
  localparam logic [11:0] STEP_C    = 12'(SCROLL_STEP);
  localparam logic [11:0] COORD_NA  = 12'hFFF;

  // Everything the register stage presents downstream, as one bundle.
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        tick;
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] rgb;
  } vid_t;

  localparam vid_t VID_RST = '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0, tick: 1'b0,
                               x: COORD_NA, y: COORD_NA, rgb: 12'h000};

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic [11:0] scroll;
  logic [11:0] scroll_sum;
  logic [11:0] scroll_nxt;
  logic [11:0] stripe_cnt;
  logic        h_last;
  logic        v_last;
  logic        h_act;
  logic        v_act;
  logic        de_c;
  logic        frame_pt;
  vid_t        vid_c;
  vid_t        vid_q;

  assign h_last   = (h_cnt == H_LAST);
  assign v_last   = (v_cnt == V_LAST);
  assign h_act    = (h_cnt < H_ACT_C);
  assign v_act    = (v_cnt < V_ACT_C);
  assign de_c     = h_act && v_act;
  // First pixel of vertical blanking: drives both the tick and the scroll update.
  assign frame_pt = (h_cnt == 12'd0) && (v_cnt == V_ACT_C);

  // Pixel counter: free-running across the whole line, wraps at H_TOTAL.
  always_ff @(posedge vga_clk) begin
    if (!rstn)       h_cnt <= '0;
    else if (h_last) h_cnt <= '0;
    else             h_cnt <= h_cnt + 12'd1;
  end

  // Line counter: steps once per line wrap, wraps at V_TOTAL.
  always_ff @(posedge vga_clk) begin
    if (!rstn)       v_cnt <= '0;
    else if (h_last) v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
  end

  // Scroll offset modulo the stripe period; one conditional subtract suffices
  // because the step is always smaller than the period.
  always_comb begin
    scroll_sum = scroll + STEP_C;
    scroll_nxt = (scroll_sum >= STRIPE_P) ? scroll_sum - STRIPE_P : scroll_sum;
  end

  // Scroll advances once per frame, only if run is high at that instant.
  always_ff @(posedge vga_clk) begin
    if (!rstn)                scroll <= '0;
    else if (frame_pt && run) scroll <= scroll_nxt;
  end

  // Stripe phase: reseeded from scroll just before pixel 0, then counts
  // pixels modulo the stripe period so no divider is needed.
  always_ff @(posedge vga_clk) begin
    if (!rstn)       stripe_cnt <= '0;
    else if (h_last) stripe_cnt <= scroll;
    else if (de_c)   stripe_cnt <= (stripe_cnt == STRIPE_LM) ? 12'd0 : stripe_cnt + 12'd1;
  end

  // Decode the current counter state into the outgoing pixel description.
  always_comb begin
    vid_c      = VID_RST;
    vid_c.hs   = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vid_c.vs   = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    vid_c.de   = de_c;
    vid_c.tick = frame_pt;
    if (de_c) begin
      vid_c.x = h_cnt;
      vid_c.y = v_cnt;
      if (v_cnt < GROUND_C)          vid_c.rgb = SKY_RGB;
      else if (stripe_cnt < STRIPE_C) vid_c.rgb = GROUND_A;
      else                            vid_c.rgb = GROUND_B;
    end
  end

  // Single output register stage; reset drops any sync pulse in progress.
  always_ff @(posedge vga_clk) begin
    if (!rstn) vid_q <= VID_RST;
    else       vid_q <= vid_c;
  end

  assign hs         = vid_q.hs;
  assign vs         = vid_q.vs;
  assign de         = vid_q.de;
  assign frame_tick = vid_q.tick;
  assign pix_x      = vid_q.x;
  assign pix_y      = vid_q.y;
  assign rgb        = vid_q.rgb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks vga_timing_gen on a shrunken raster
// (24 clocks x 17 lines) so whole frames and scroll wraps fit in a short run.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 12, VFP = 1, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;   // 24
  localparam int VT = VA + VFP + VSW + VBP;   // 17
  localparam int GY = 8, SW = 4, STEP = 3;
  localparam logic [11:0] SKY = 12'h4CF, GA = 12'h8C4, GB = 12'h6A3;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        tick;
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] rgb;
  } out_t;

  typedef struct {
    int   k;
    out_t exp;
  } vec_t;

  localparam out_t RST_OUT = '{hs: 1'b1, vs: 1'b1, de: 1'b0, tick: 1'b0,
                               x: 12'hFFF, y: 12'hFFF, rgb: 12'h000};

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        run = 1'b0;
  logic        hs, vs, de, frame_tick;
  logic [11:0] pix_x, pix_y, rgb;

  int tests = 0;
  int fails = 0;
  int out_idx = 0;
  int mh = 0, mv = 0, ms = 0;
  out_t sb[$];

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(1'b0), .GROUND_Y(GY), .STRIPE_W(SW), .SCROLL_STEP(STEP),
    .SKY_RGB(SKY), .GROUND_A(GA), .GROUND_B(GB)
  ) dut (
    .vga_clk(clk), .rstn(rstn), .run(run),
    .hs(hs), .vs(vs), .de(de), .pix_x(pix_x), .pix_y(pix_y),
    .rgb(rgb), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic out_t cur_out();
    return '{hs: hs, vs: vs, de: de, tick: frame_tick, x: pix_x, y: pix_y, rgb: rgb};
  endfunction

  // Reference: what the pixel at (h,v) should look like given the frame's scroll.
  function automatic out_t model(int h, int v, int s);
    out_t o;
    o      = RST_OUT;
    o.hs   = !(h >= HA + HFP && h < HA + HFP + HSW);
    o.vs   = !(v >= VA + VFP && v < VA + VFP + VSW);
    o.tick = (h == 0 && v == VA);
    o.de   = (h < HA && v < VA);
    if (o.de) begin
      o.x   = 12'(h);
      o.y   = 12'(v);
      o.rgb = (v < GY) ? SKY : (((s + h) % (2 * SW)) < SW ? GA : GB);
    end
    return o;
  endfunction

  function automatic vec_t mk(int k, logic h, logic v, logic d, logic t,
                              logic [11:0] x, logic [11:0] y, logic [11:0] c);
    vec_t r;
    r.k   = k;
    r.exp = '{hs: h, vs: v, de: d, tick: t, x: x, y: y, rgb: c};
    return r;
  endfunction

  // Index of the output currently on the pins, counted from reset release.
  always @(posedge clk) out_idx <= rstn ? out_idx + 1 : -1;

  // Scoreboard producer: expected output for this edge, then advance the model.
  always @(posedge clk) begin
    if (!rstn) begin
      sb.push_back(RST_OUT);
      mh <= 0; mv <= 0; ms <= 0;
    end else begin
      sb.push_back(model(mh, mv, ms));
      mh <= (mh == HT - 1) ? 0 : mh + 1;
      if (mh == HT - 1) mv <= (mv == VT - 1) ? 0 : mv + 1;
      if (mh == 0 && mv == VA && run) ms <= (ms + STEP) % (2 * SW);
    end
  end

  // Scoreboard consumer: compare every output cycle away from the active edge.
  always @(negedge clk) begin
    out_t e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = cur_out();
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL sb idx=%0d got hs=%b vs=%b de=%b tk=%b x=%h y=%h rgb=%h exp hs=%b vs=%b de=%b tk=%b x=%h y=%h rgb=%h",
                 out_idx, a.hs, a.vs, a.de, a.tick, a.x, a.y, a.rgb,
                 e.hs, e.vs, e.de, e.tick, e.x, e.y, e.rgb);
      end
    end
  end

  task automatic wait_out(input int k);
    for (int i = 0; i < 20000; i++) begin
      if (out_idx == k) break;
      @(negedge clk);
    end
    if (out_idx != k) begin
      tests++; fails++;
      $display("FAIL timeout waiting for idx %0d, at %0d", k, out_idx);
    end
  endtask

  task automatic chk_out(input string name, input out_t exp);
    out_t a;
    a = cur_out();
    tests++;
    if (a !== exp) begin
      fails++;
      $display("FAIL %s idx=%0d got %h exp %h", name, out_idx, a, exp);
    end
  endtask

  task automatic chk_rgb(input int k, input logic [11:0] exp);
    wait_out(k);
    tests++;
    if (rgb !== exp) begin
      fails++;
      $display("FAIL rgb idx=%0d got %h exp %h", k, rgb, exp);
    end
  endtask

  vec_t tbl[26];

  initial begin
    // Hand-derived checkpoints for one frame and a bit, run=0, scroll=0.
    tbl[0]  = mk(0,   1, 1, 1, 0, 12'd0,  12'd0,  SKY);
    tbl[1]  = mk(15,  1, 1, 1, 0, 12'd15, 12'd0,  SKY);
    tbl[2]  = mk(16,  1, 1, 0, 0, 12'hFFF, 12'hFFF, 12'h000);
    tbl[3]  = mk(17,  1, 1, 0, 0, 12'hFFF, 12'hFFF, 12'h000);
    tbl[4]  = mk(18,  0, 1, 0, 0, 12'hFFF, 12'hFFF, 12'h000);
    tbl[5]  = mk(20,  0, 1, 0, 0, 12'hFFF, 12'hFFF, 12'h000);
    tbl[6]  = mk(21,  1, 1, 0, 0, 12'hFFF, 12'hFFF, 12'h000);
    tbl[7]  = mk(23,  1, 1, 0, 0, 12'hFFF, 12'hFFF, 12'h000);
    tbl[8]  = mk(24,  1, 1, 1, 0, 12'd0,  12'd1,  SKY);
    tbl[9]  = mk(173, 1, 1, 1, 0, 12'd5,  12'd7,  SKY);
    tbl[10] = mk(192, 1, 1, 1, 0, 12'd0,  12'd8,  GA);
    tbl[11] = mk(195, 1, 1, 1, 0, 12'd3,  12'd8,  GA);
    tbl[12] = mk(196, 1, 1, 1, 0, 12'd4,  12'd8,  GB);
    tbl[13] = mk(199, 1, 1, 1, 0, 12'd7,  12'd8,  GB);
    tbl[14] = mk(200, 1, 1, 1, 0, 12'd8,  12'd8,  GA);
    tbl[15] = mk(287, 1, 1, 0, 0, 12'hFFF, 12'hFFF, 12'h000);
    tbl[16] = mk(288, 1, 1, 0, 1, 12'hFFF, 12'hFFF, 12'h000);
    tbl[17] = mk(289, 1, 1, 0, 0, 12'hFFF, 12'hFFF, 12'h000);
    tbl[18] = mk(311, 1, 1, 0, 0, 12'hFFF, 12'hFFF, 12'h000);
    tbl[19] = mk(312, 1, 0, 0, 0, 12'hFFF, 12'hFFF, 12'h000);
    tbl[20] = mk(359, 1, 0, 0, 0, 12'hFFF, 12'hFFF, 12'h000);
    tbl[21] = mk(360, 1, 1, 0, 0, 12'hFFF, 12'hFFF, 12'h000);
    tbl[22] = mk(407, 1, 1, 0, 0, 12'hFFF, 12'hFFF, 12'h000);
    tbl[23] = mk(408, 1, 1, 1, 0, 12'd0,  12'd0,  SKY);
    tbl[24] = mk(600, 1, 1, 1, 0, 12'd0,  12'd8,  GA);
    tbl[25] = mk(604, 1, 1, 1, 0, 12'd4,  12'd8,  GB);

    // Power-up reset with scroll frozen.
    repeat (3) @(negedge clk);
    chk_out("reset_hold", RST_OUT);
    rstn = 1'b1;
    for (int i = 0; i < 26; i++) begin
      wait_out(tbl[i].k);
      chk_out($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Scrolling: scroll per frame goes 0,3,6,1,... and is back to 0 at frame 8.
    @(negedge clk); rstn = 1'b0; run = 1'b1;
    @(negedge clk); rstn = 1'b1;
    chk_rgb(600,  GA);   // frame 1, scroll 3: x0 -> phase 3
    chk_rgb(601,  GB);   // x1 -> phase 4
    chk_rgb(1418, GA);   // frame 3, scroll wrapped to 1: x2 -> phase 3
    chk_rgb(1419, GB);
    chk_rgb(3459, GA);   // frame 8, scroll 0 again
    chk_rgb(3460, GB);
    chk_rgb(3464, GA);

    // Mid-line reset in frame 9 (scroll 3), line 5.
    wait_out(9 * 408 + 5 * 24 + 10);
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out($sformatf("midreset%0d", i), RST_OUT);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk_out("restart00", '{hs: 1'b1, vs: 1'b1, de: 1'b1, tick: 1'b0,
                           x: 12'd0, y: 12'd0, rgb: SKY});
    chk_rgb(195, GA);    // scroll cleared: phase 3 is stripe A
    chk_rgb(196, GB);
    wait_out(450);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
